ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the execute-stage ALU in the DLX pipeline.
- Captures the ALU result and zero flag together with the EX-stage control bundle into the EX/MEM pipeline register.
- Resolves conditional branches and jumps, and drives a one-cycle redirect/flush pulse to the front end.
- Exposes an EX/MEM forwarding port; counts retired taken branches.

Parameters:
- XLEN, 32, datapath width (ALU result, store data, PC).
- REG_AW, 5, register-file address width.
- CNT_W, 32, width of the taken-branch counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- alu_res  in  XLEN  ALU result for the EX instruction.
- alu_zf  in  1  ALU zero/condition flag.
- ex_rd  in  REG_AW  destination register.
- ex_reg_write  in  1  instruction writes rd.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_store_data  in  XLEN  forwarded rs2 value for stores.
- ex_is_branch  in  1  conditional branch; taken when alu_zf=1.
- ex_is_jump  in  1  unconditional jump; always taken.
- ex_link  in  1  jump-and-link; writes ex_pc4 to rd instead of alu_res.
- ex_pc4  in  XLEN  PC+4 of the EX instruction.
- ex_target  in  XLEN  branch/jump target.
- mem_stall  in  1  memory stage cannot accept; hold register.
- ex_ready  out  1  stage accepts EX input this cycle.
- redirect  out  1  one-cycle pulse; front end loads redirect_pc.
- redirect_pc  out  XLEN  target for redirect.
- flush  out  1  equals redirect; IF/ID/EX kill their contents.
- mem_valid  out  1  EX/MEM holds a valid instruction.
- mem_rd  out  REG_AW  registered destination.
- mem_reg_write  out  1  registered write enable; forced 0 when rd=0.
- mem_mem_read  out  1  registered load.
- mem_mem_write  out  1  registered store.
- mem_result  out  XLEN  registered alu_res, or ex_pc4 when ex_link.
- mem_store_data  out  XLEN  registered store data.
- fwd_valid  out  1  mem_valid & mem_reg_write & ~mem_mem_read.
- fwd_rd  out  REG_AW  equals mem_rd.
- fwd_data  out  XLEN  equals mem_result.
- taken_count  out  CNT_W  number of taken branches/jumps accepted.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All registered outputs clear to 0, including mem_valid, redirect, redirect_pc and taken_count.
  - Reset has priority over every other event, including mid-stall and mid-redirect.
- ex_ready = ~mem_stall, combinational.
- Accept (ex_ready=1):
  - The register loads the EX bundle.
  - mem_valid <= ex_valid & ~redirect. The EX instruction present during a redirect cycle is a wrong-path instruction and is squashed to a bubble.
  - A bubble clears mem_reg_write, mem_mem_read and mem_mem_write; data fields don't-care.
- Hold (mem_stall=1):
  - All EX/MEM fields keep their value.
  - No branch is resolved; taken_count is unchanged.
- Branch resolution:
  - take = ex_ready & ex_valid & ~redirect & (ex_is_jump | (ex_is_branch & alu_zf)).
  - On take: next cycle redirect=1 and redirect_pc=ex_target (registered); taken_count increments, wrapping at 2^CNT_W.
  - redirect is exactly one cycle wide, independent of mem_stall in that cycle.
  - Back-to-back take is impossible: the next EX input is squashed by the redirect.
  - Latency: branch in EX in cycle N gives redirect in cycle N+1; the instruction arriving in N+1 is killed.
- r0 rule: ex_rd=0 forces mem_reg_write=0 and fwd_valid=0.
- ex_is_branch and ex_is_jump both set: treat as jump.
- Forwarding outputs are purely combinational from the EX/MEM register.

Decomposition:
- Package dlx_pkg:
  - XLEN and REG_AW constants.
  - struct ex_mem_t {valid, rd, reg_write, mem_read, mem_write, result, store_data}.
  - The shared ALU-op encoding enum used by decode and the ALU.
- One sub-module: branch_resolve, combinational take/target logic plus the redirect register and counter.
- The EX/MEM register stays in ex_mem_stage.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with ex_valid=1 -> mem_valid=0, redirect=0, taken_count=0 after release.
- ALU op: ex_valid=1, alu_res=0x0000_0010, rd=3, reg_write=1 -> next cycle mem_result=0x10, fwd_valid=1, fwd_rd=3.
- Taken branch: ex_is_branch=1, alu_zf=1, ex_target=0x100 in cycle N -> redirect=1 and redirect_pc=0x100 only in N+1; instruction presented in N+1 yields mem_valid=0 in N+2; taken_count=1.
- Not taken: ex_is_branch=1, alu_zf=0 -> no redirect; taken_count unchanged.
- Stall: mem_stall=1 for 3 cycles with a jump in EX -> EX/MEM frozen, ex_ready=0, no redirect; on release -> redirect the following cycle.
- r0 and link:
  - rd=0, reg_write=1 -> mem_reg_write=0, fwd_valid=0.
  - ex_link=1, ex_pc4=0x44 -> mem_result=0x44.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX pipeline types: datapath widths, the EX/MEM register layout and the ALU-op encoding.
package dlx_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI, ALU_SEQ
    } alu_op_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   store_data;
    } ex_mem_t;
endpackage

// File: rtl/branch_resolve.sv
// Branch/jump resolution: decides take in EX, registers the one-cycle redirect and counts taken branches.
module branch_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_ready,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             alu_zf,
    input  logic [XLEN-1:0]  ex_target,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] taken_count
);
    logic take;

    // The instruction in EX during a redirect is wrong-path, so it can never resolve as taken.
    assign take = ex_ready & ex_valid & ~redirect & (ex_is_jump | (ex_is_branch & alu_zf));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
            taken_count <= '0;
        end else begin
            redirect <= take;
            if (take) begin
                redirect_pc <= ex_target;
                taken_count <= taken_count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: captures the ALU result and control bundle, resolves branches, exposes forwarding.
module ex_mem_stage #(
    parameter int XLEN   = dlx_pkg::XLEN,
    parameter int REG_AW = dlx_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   alu_res,
    input  logic              alu_zf,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic              ex_link,
    input  logic [XLEN-1:0]   ex_pc4,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              mem_stall,
    output logic              ex_ready,
    output logic              redirect,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush,
    output logic              mem_valid,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic [XLEN-1:0]   mem_result,
    output logic [XLEN-1:0]   mem_store_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic [CNT_W-1:0]  taken_count
);
    import dlx_pkg::*;

    ex_mem_t q;
    logic    live;

    assign ex_ready = ~mem_stall;
    assign live     = ex_valid & ~redirect;

    branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) u_br (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .ex_is_branch(ex_is_branch),
        .ex_is_jump  (ex_is_jump),
        .alu_zf      (alu_zf),
        .ex_target   (ex_target),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .taken_count (taken_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ex_ready) begin
            q.valid      <= live;
            q.rd         <= ex_rd;
            // Writes to r0 are dropped here so forwarding never matches r0.
            q.reg_write  <= live & ex_reg_write & (ex_rd != '0);
            q.mem_read   <= live & ex_mem_read;
            q.mem_write  <= live & ex_mem_write;
            q.result     <= ex_link ? ex_pc4 : alu_res;
            q.store_data <= ex_store_data;
        end
    end

    assign flush          = redirect;
    assign mem_valid      = q.valid;
    assign mem_rd         = q.rd;
    assign mem_reg_write  = q.reg_write;
    assign mem_mem_read   = q.mem_read;
    assign mem_mem_write  = q.mem_write;
    assign mem_result     = q.result;
    assign mem_store_data = q.store_data;

    // Loads are excluded: their data only exists after the memory access.
    assign fwd_valid = q.valid & q.reg_write & ~q.mem_read;
    assign fwd_rd    = q.rd;
    assign fwd_data  = q.result;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic against a reference model.
module tb_ex_mem_stage;
    localparam int XLEN = 32, REG_AW = 5, CNT_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid, alu_zf, ex_reg_write, ex_mem_read, ex_mem_write;
    logic              ex_is_branch, ex_is_jump, ex_link, mem_stall;
    logic [XLEN-1:0]   alu_res, ex_store_data, ex_pc4, ex_target;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_ready, redirect, flush, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, fwd_valid;
    logic [XLEN-1:0]   redirect_pc, mem_result, mem_store_data, fwd_data;
    logic [REG_AW-1:0] mem_rd, fwd_rd;
    logic [CNT_W-1:0]  taken_count;

    always #5 clk = ~clk;

    ex_mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_res(alu_res), .alu_zf(alu_zf),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_link(ex_link), .ex_pc4(ex_pc4), .ex_target(ex_target),
        .mem_stall(mem_stall), .ex_ready(ex_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .taken_count(taken_count)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: what the EX/MEM register and redirect state should hold.
    logic              m_valid, m_rw, m_rd_en, m_wr_en, m_redir;
    logic [REG_AW-1:0] m_rd;
    logic [XLEN-1:0]   m_res, m_sd, m_rpc;
    logic [CNT_W-1:0]  m_cnt;

    task automatic clear_in();
        ex_valid = 0; alu_res = 0; alu_zf = 0; ex_rd = 0; ex_reg_write = 0;
        ex_mem_read = 0; ex_mem_write = 0; ex_store_data = 0; ex_is_branch = 0;
        ex_is_jump = 0; ex_link = 0; ex_pc4 = 0; ex_target = 0; mem_stall = 0;
    endtask

    // One clock: check ex_ready, advance the model at the edge, compare registered outputs at negedge.
    task automatic cyc();
        logic taken, wrong_path;
        #1;
        chk("ex_ready", ex_ready, !mem_stall);
        @(posedge clk);
        if (!rst_n) begin
            {m_valid, m_rw, m_rd_en, m_wr_en, m_redir} = '0;
            m_rd = 0; m_res = 0; m_sd = 0; m_rpc = 0; m_cnt = 0;
        end else begin
            wrong_path = m_redir;
            taken = !mem_stall && ex_valid && !wrong_path && (ex_is_jump || (ex_is_branch && alu_zf));
            if (!mem_stall) begin
                m_valid = ex_valid && !wrong_path;
                m_rd    = ex_rd;
                m_rw    = m_valid && ex_reg_write && (ex_rd != 0);
                m_rd_en = m_valid && ex_mem_read;
                m_wr_en = m_valid && ex_mem_write;
                m_res   = ex_link ? ex_pc4 : alu_res;
                m_sd    = ex_store_data;
            end
            m_redir = taken;
            if (taken) begin
                m_rpc = ex_target;
                m_cnt = m_cnt + 1;
            end
        end
        @(negedge clk);
        chk("mem_valid", mem_valid, m_valid);
        chk("mem_reg_write", mem_reg_write, m_rw);
        chk("mem_mem_read", mem_mem_read, m_rd_en);
        chk("mem_mem_write", mem_mem_write, m_wr_en);
        chk("fwd_valid", fwd_valid, m_valid && m_rw && !m_rd_en);
        chk("redirect", redirect, m_redir);
        chk("flush", flush, m_redir);
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("taken_count", taken_count, m_cnt);
        if (m_valid) begin
            chk("mem_rd", mem_rd, m_rd);
            chk("fwd_rd", fwd_rd, m_rd);
            chk("mem_result", mem_result, m_res);
            chk("fwd_data", fwd_data, m_res);
            chk("mem_store_data", mem_store_data, m_sd);
        end
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        ex_valid = 1;
        @(negedge clk);
        cyc(); cyc();
        rst_n = 1;
        clear_in();
        cyc();
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_redirect", redirect, 0);
        chk("rst_count", taken_count, 0);

        // Plain ALU op
        ex_valid = 1; alu_res = 32'h10; ex_rd = 3; ex_reg_write = 1;
        cyc();
        chk("alu_result", mem_result, 32'h10);
        chk("alu_fwd_valid", fwd_valid, 1);
        chk("alu_fwd_rd", fwd_rd, 3);

        // Taken branch, then a wrong-path instruction that must be squashed
        clear_in();
        ex_valid = 1; ex_is_branch = 1; alu_zf = 1; ex_target = 32'h100;
        cyc();
        chk("br_redirect", redirect, 1);
        chk("br_redirect_pc", redirect_pc, 32'h100);
        clear_in();
        ex_valid = 1; ex_rd = 5; ex_reg_write = 1; ex_is_jump = 1; ex_target = 32'h200;
        cyc();
        chk("br_squash_valid", mem_valid, 0);
        chk("br_pulse_end", redirect, 0);
        chk("br_count", taken_count, 1);

        // Not-taken branch
        clear_in();
        ex_valid = 1; ex_is_branch = 1; alu_zf = 0; ex_target = 32'h300;
        cyc();
        chk("nt_redirect", redirect, 0);
        chk("nt_count", taken_count, 1);

        // Jump held by a 3-cycle stall, released afterwards
        clear_in();
        ex_valid = 1; ex_is_jump = 1; ex_target = 32'h400; mem_stall = 1;
        repeat (3) begin
            cyc();
            chk("stall_no_redirect", redirect, 0);
        end
        mem_stall = 0;
        cyc();
        chk("stall_release_redirect", redirect, 1);
        chk("stall_release_pc", redirect_pc, 32'h400);
        chk("stall_release_count", taken_count, 2);

        // r0 write suppression, then jump-and-link result
        clear_in();
        cyc();
        ex_valid = 1; ex_rd = 0; ex_reg_write = 1; alu_res = 32'hdead;
        cyc();
        chk("r0_reg_write", mem_reg_write, 0);
        chk("r0_fwd_valid", fwd_valid, 0);
        ex_rd = 31; ex_link = 1; ex_pc4 = 32'h44;
        cyc();
        chk("link_result", mem_result, 32'h44);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst_n         = ($urandom_range(0, 79) != 0);
            ex_valid      = ($urandom_range(0, 3) != 0);
            alu_res       = $urandom;
            alu_zf        = $urandom_range(0, 1);
            ex_rd         = ($urandom_range(0, 5) == 0) ? 5'd0 : REG_AW'($urandom);
            ex_reg_write  = $urandom_range(0, 1);
            ex_mem_read   = ($urandom_range(0, 3) == 0);
            ex_mem_write  = ($urandom_range(0, 3) == 0);
            ex_store_data = $urandom;
            ex_is_branch  = ($urandom_range(0, 3) == 0);
            ex_is_jump    = ($urandom_range(0, 6) == 0);
            ex_link       = ($urandom_range(0, 4) == 0);
            ex_pc4        = $urandom;
            ex_target     = $urandom;
            mem_stall     = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
